// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// The forward-select values match the Execute-stage mux3 select encoding.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t   rs1;
        reg_idx_t   rs2;
        reg_idx_t   rd;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_access;
    } slot_e_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_access;
    } slot_m_t;

    typedef struct packed {
        reg_idx_t rd;
        logic     reg_write;
    } slot_w_t;

    // M wins over W so the youngest producer of a register is forwarded.
    function automatic logic [1:0] fwd_sel(
        input reg_idx_t rs,
        input reg_idx_t rd_m,
        input logic     rw_m,
        input reg_idx_t rd_w,
        input logic     rw_w
    );
        if ((rs != '0) && rw_m && (rd_m == rs)) begin
            return FWD_MEM;
        end
        if ((rs != '0) && rw_w && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode/Execute/Memory-side hazard signals exchanged between the core
// datapath (master) and the hazard unit (slave).
interface hazard_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] Rs1D;
    logic [REG_W-1:0] Rs2D;
    logic [REG_W-1:0] RdD;
    logic             RegWriteD;
    logic [1:0]       ResultSrcD;
    logic             MemAccessD;
    logic             PCSrcE;
    logic             DmemReadyM;

    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallEMW;
    logic             FlushD;
    logic             FlushE;
    logic             MemTimeout;

    modport master (
        output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemAccessD,
        output PCSrcE, DmemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallEMW,
        input  FlushD, FlushE, MemTimeout
    );

    modport slave (
        input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, MemAccessD,
        input  PCSrcE, DmemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallEMW,
        output FlushD, FlushE, MemTimeout
    );

endinterface

// File: rtl/hazard_track.sv
// E/M/W register-metadata shift register. hold_i freezes every slot;
// bubble_i loads an all-zero E slot while M and W still advance.
module hazard_track
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    hold_i,
    input  logic    bubble_i,
    input  slot_e_t slot_d_i,
    output slot_e_t slot_e_o,
    output slot_m_t slot_m_o,
    output slot_w_t slot_w_o
);

    slot_e_t e_q, e_d;
    slot_m_t m_q, m_d;
    slot_w_t w_q, w_d;

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (!hold_i) begin
            e_d = bubble_i ? '0 : slot_d_i;
            m_d.rd         = e_q.rd;
            m_d.reg_write  = e_q.reg_write;
            m_d.mem_access = e_q.mem_access;
            w_d.rd         = m_q.rd;
            w_d.reg_write  = m_q.reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign slot_e_o = e_q;
    assign slot_m_o = m_q;
    assign slot_w_o = w_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use / branch / slow
// data-memory stall and flush generation, and a sticky memory-wait watchdog.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hz
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MEM_TIMEOUT);

    slot_e_t slot_d;
    slot_e_t slot_e;
    slot_m_t slot_m;
    slot_w_t slot_w;

    logic mem_stall;
    logic lw_stall;
    logic flush_e;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        slot_d            = '0;
        slot_d.rs1        = hz.Rs1D;
        slot_d.rs2        = hz.Rs2D;
        slot_d.rd         = hz.RdD;
        slot_d.reg_write  = hz.RegWriteD;
        slot_d.result_src = hz.ResultSrcD;
        slot_d.mem_access = hz.MemAccessD;
    end

    assign mem_stall = slot_m.mem_access & ~hz.DmemReadyM;

    assign lw_stall = (slot_e.result_src == RES_LOAD) &&
                      (slot_e.rd != '0) &&
                      ((hz.Rs1D == slot_e.rd) || (hz.Rs2D == slot_e.rd));

    // A stalled memory access suppresses all flushes so nothing is lost
    // while the pipeline is frozen.
    assign flush_e = (lw_stall | hz.PCSrcE) & ~mem_stall;

    hazard_track u_track (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold_i   (mem_stall),
        .bubble_i (flush_e),
        .slot_d_i (slot_d),
        .slot_e_o (slot_e),
        .slot_m_o (slot_m),
        .slot_w_o (slot_w)
    );

    assign hz.ForwardAE = fwd_sel(slot_e.rs1, slot_m.rd, slot_m.reg_write,
                                  slot_w.rd, slot_w.reg_write);
    assign hz.ForwardBE = fwd_sel(slot_e.rs2, slot_m.rd, slot_m.reg_write,
                                  slot_w.rd, slot_w.reg_write);

    assign hz.StallF     = lw_stall | mem_stall;
    assign hz.StallD     = lw_stall | mem_stall;
    assign hz.StallEMW   = mem_stall;
    assign hz.FlushD     = hz.PCSrcE & ~mem_stall;
    assign hz.FlushE     = flush_e;
    assign hz.MemTimeout = timeout_q;

    // wait_cnt_d is the number of consecutive stalled cycles including this
    // one, so the flag sets on the edge closing the MEM_TIMEOUT-th cycle.
    always_comb begin
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q
                                                 : wait_cnt_q + CNT_W'(1);
            if (wait_cnt_d >= TIMEOUT_LIM) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule
